count_ctrl: RTL and testbench

//  Run-control sequencer for the 4-bit LED binary counter: owns the prescaler, count register and run state.

---
 rtl/count_ctrl_pkg.sv | 40 ++++
 rtl/count_ctrl_if.sv | 14 +
 rtl/count_ctrl_prescaler.sv | 45 ++++
 rtl/count_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_count_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/count_ctrl_pkg.sv
// Shared encodings and helpers for the LED counter run-control sequencer.
// Opcodes, FSM states and the 4-bit count arithmetic used by count_ctrl.
package count_ctrl_pkg;

    localparam int LED_W = 4;
    localparam int OP_W  = 3;

    localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
    localparam logic [OP_W-1:0] OP_START = 3'd1;
    localparam logic [OP_W-1:0] OP_STOP  = 3'd2;
    localparam logic [OP_W-1:0] OP_STEP  = 3'd3;
    localparam logic [OP_W-1:0] OP_LOAD  = 3'd4;
    localparam logic [OP_W-1:0] OP_RATE  = 3'd5;
    localparam logic [OP_W-1:0] OP_DIR   = 3'd6;
    localparam logic [OP_W-1:0] OP_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    function automatic logic [LED_W-1:0] led_next(input logic [LED_W-1:0] v, input logic down);
        if (down) begin
            return v - LED_W'(1);
        end else begin
            return v + LED_W'(1);
        end
    endfunction

    // True when the next increment in the given direction rolls over.
    function automatic logic led_wraps(input logic [LED_W-1:0] v, input logic down);
        if (down) begin
            return (v == {LED_W{1'b0}});
        end else begin
            return (v == {LED_W{1'b1}});
        end
    endfunction

endpackage

// File: rtl/count_ctrl_if.sv
// Single-beat valid/ready command port into count_ctrl.
// The host drives through the master modport; the sequencer accepts through slave.
interface count_ctrl_if;
    import count_ctrl_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic [LED_W-1:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);

endinterface

// File: rtl/count_ctrl_prescaler.sv
// Free-running prescaler for count_ctrl: counts while enabled, wraps at a rate-scaled
// terminal and flags the terminal cycle combinationally so the owner can veto it.
module count_prescaler #(
    parameter int PRESCALE_W = 25,
    parameter int RATE_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [RATE_W-1:0] rate_i,
    output logic              term_o
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;
    logic [PRESCALE_W-1:0] term_s;

    assign term_s = {PRESCALE_W{1'b1}} >> rate_i;
    assign term_o = en_i && (cnt_q == term_s);

    // Next prescaler value: clear has priority, then wrap at terminal, then count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {PRESCALE_W{1'b0}};
        end else if (term_o) begin
            cnt_d = {PRESCALE_W{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {PRESCALE_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/count_ctrl.sv
// Run-control sequencer for the 4-bit LED counter: command decode, IDLE/RUN/STEP FSM,
// count register and registered tick/wrap/error pulses. Down counting via COUNT_CTRL_DOWN_EN.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int PRESCALE_W = 25,
    parameter int RATE_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    count_ctrl_if.slave      cmd,
    output logic [LED_W-1:0] count_out,
    output logic             running,
    output logic             tick,
    output logic             wrap,
    output logic             cmd_err
);

    state_e            state_q;
    state_e            state_d;
    logic [LED_W-1:0]  count_q;
    logic [LED_W-1:0]  count_d;
    logic [RATE_W-1:0] rate_q;
    logic [RATE_W-1:0] rate_d;
    logic              running_q;
    logic              tick_q;
    logic              wrap_q;
    logic              err_q;

    logic              accept_s;
    logic              term_s;
    logic              clr_s;
    logic              kill_s;
    logic              load_s;
    logic              err_s;
    logic              step_inc_s;
    logic              inc_s;
    logic              wrap_s;
    logic              dir_s;

    assign cmd.cmd_ready = (state_q != ST_STEP);
    assign accept_s      = cmd.cmd_valid && cmd.cmd_ready;

    count_prescaler #(
        .PRESCALE_W (PRESCALE_W),
        .RATE_W     (RATE_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr_s),
        .en_i   (state_q == ST_RUN),
        .rate_i (rate_q),
        .term_o (term_s)
    );

`ifdef COUNT_CTRL_DOWN_EN
    logic dir_q;
    logic dir_wr_s;

    // Direction register, applied from the increment after the DIR command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_q <= 1'b0;
        end else if (dir_wr_s) begin
            dir_q <= cmd.cmd_data[0];
        end else begin
            dir_q <= dir_q;
        end
    end

    assign dir_s = dir_q;
`else
    assign dir_s = 1'b0;
`endif

    // Command decode and FSM; an accepted STOP/LOAD/RATE vetoes a coincident tick.
    always_comb begin
        state_d    = state_q;
        rate_d     = rate_q;
        clr_s      = 1'b0;
        kill_s     = 1'b0;
        load_s     = 1'b0;
        err_s      = 1'b0;
        step_inc_s = 1'b0;
`ifdef COUNT_CTRL_DOWN_EN
        dir_wr_s   = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (accept_s) begin
                    case (cmd.cmd_op)
                        OP_NOP: begin
                            state_d = state_q;
                        end
                        OP_START: begin
                            if (state_q == ST_IDLE) begin
                                state_d = ST_RUN;
                                clr_s   = 1'b1;
                            end else begin
                                state_d = state_q;
                            end
                        end
                        OP_STOP: begin
                            if (state_q == ST_RUN) begin
                                state_d = ST_IDLE;
                                clr_s   = 1'b1;
                                kill_s  = 1'b1;
                            end else begin
                                state_d = state_q;
                            end
                        end
                        OP_STEP: begin
                            if (state_q == ST_IDLE) begin
                                state_d = ST_STEP;
                            end else begin
                                err_s = 1'b1;
                            end
                        end
                        OP_LOAD: begin
                            load_s = 1'b1;
                            clr_s  = 1'b1;
                            kill_s = 1'b1;
                        end
                        OP_RATE: begin
                            if (int'(cmd.cmd_data) > PRESCALE_W - 1) begin
                                rate_d = RATE_W'(PRESCALE_W - 1);
                            end else begin
                                rate_d = RATE_W'(cmd.cmd_data);
                            end
                            clr_s  = 1'b1;
                            kill_s = 1'b1;
                        end
                        OP_DIR: begin
`ifdef COUNT_CTRL_DOWN_EN
                            dir_wr_s = 1'b1;
`else
                            err_s = 1'b1;
`endif
                        end
                        default: begin
                            err_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            ST_STEP: begin
                step_inc_s = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        inc_s  = step_inc_s || (term_s && !kill_s);
        wrap_s = inc_s && led_wraps(count_q, dir_s);
        if (load_s) begin
            count_d = cmd.cmd_data;
        end else if (inc_s) begin
            count_d = led_next(count_q, dir_s);
        end else begin
            count_d = count_q;
        end
    end

    // State, count, rate and the single-cycle pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            count_q   <= {LED_W{1'b0}};
            rate_q    <= {RATE_W{1'b0}};
            running_q <= 1'b0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rate_q    <= rate_d;
            running_q <= (state_d == ST_RUN);
            tick_q    <= term_s && !kill_s;
            wrap_q    <= wrap_s;
            err_q     <= err_s;
        end
    end

    assign count_out = count_q;
    assign running   = running_q;
    assign tick      = tick_q;
    assign wrap      = wrap_q;
    assign cmd_err   = err_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Randomized bench for count_ctrl (PRESCALE_W=4, RATE_W=2) against a behavioural model
// of the run/step/prescale rules, plus directed boundary scenarios.
module tb_count_ctrl;

    localparam int PW = 4;
    localparam int RW = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] count_out;
    logic       running;
    logic       tick;
    logic       wrap;
    logic       cmd_err;

    count_ctrl_if ifc ();

    count_ctrl #(.PRESCALE_W(PW), .RATE_W(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (ifc),
        .count_out (count_out),
        .running   (running),
        .tick      (tick),
        .wrap      (wrap),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain run flags, elapsed-cycle counter and modulo-16 count.
    bit m_run, m_stepping, m_dir;
    int m_count, m_rate, m_elapsed;
    bit e_tick, e_wrap, e_err, e_running;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_stepping = 0; m_dir = 0;
        m_count = 0; m_rate = 0; m_elapsed = 0;
        e_tick = 0; e_wrap = 0; e_err = 0; e_running = 0;
    endtask

    task automatic model_step(input bit v, input bit [2:0] op, input bit [3:0] d);
        bit acc, hit, kill, clear, inc, load_en, nrun, nstep, ndir;
        int period, nrate;
        period  = (1 << PW) >> m_rate;
        acc     = v && !m_stepping;
        hit     = m_run && (m_elapsed == period - 1);
        kill    = 0; clear = 0; load_en = 0; nstep = 0;
        inc     = m_stepping;
        nrun    = m_run; ndir = m_dir; nrate = m_rate;
        e_err   = 0;
        if (acc) begin
            case (op)
                3'd1: if (!m_run) begin nrun = 1; clear = 1; end
                3'd2: if (m_run) begin nrun = 0; clear = 1; kill = 1; end
                3'd3: if (m_run) e_err = 1; else nstep = 1;
                3'd4: begin load_en = 1; clear = 1; kill = 1; end
                3'd5: begin nrate = (d > PW - 1) ? PW - 1 : int'(d); clear = 1; kill = 1; end
`ifdef COUNT_CTRL_DOWN_EN
                3'd6: ndir = d[0];
`else
                3'd6: e_err = 1;
`endif
                3'd7: e_err = 1;
                default: ;
            endcase
        end
        e_tick = hit && !kill;
        if (e_tick) inc = 1;
        e_wrap = inc && (m_dir ? (m_count == 0) : (m_count == 15));
        if (load_en) m_count = int'(d);
        else if (inc) m_count = m_dir ? (m_count + 15) % 16 : (m_count + 1) % 16;
        if (clear || hit) m_elapsed = 0;
        else if (m_run) m_elapsed++;
        m_run = nrun; m_stepping = nstep; m_dir = ndir; m_rate = nrate;
        e_running = nrun;
    endtask

    // One clock: check ready, drive a command at negedge, compare all outputs after posedge.
    task automatic cyc(input bit v, input bit [2:0] op, input bit [3:0] d);
        @(negedge clk);
        check_val("cmd_ready", ifc.cmd_ready, m_stepping ? 0 : 1);
        ifc.cmd_valid = v;
        ifc.cmd_op    = op;
        ifc.cmd_data  = d;
        model_step(v, op, d);
        @(posedge clk);
        #1;
        check_val("count_out", count_out, m_count);
        check_val("running", running, e_running);
        check_val("tick", tick, e_tick);
        check_val("wrap", wrap, e_wrap);
        check_val("cmd_err", cmd_err, e_err);
    endtask

    task automatic reset_mid();
        #2;
        rst = 1'b0;
        ifc.cmd_valid = 1'b0;
        #1;
        check_val("rst_count", count_out, 0);
        check_val("rst_running", running, 0);
        check_val("rst_tick", tick, 0);
        check_val("rst_wrap", wrap, 0);
        check_val("rst_err", cmd_err, 0);
        check_val("rst_ready", ifc.cmd_ready, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc(0, 3'd0, 4'd0);
            n++;
        end while (!tick && n < 64);
    endtask

    task automatic wait_hit();
        int k = 0;
        while (!(m_run && m_elapsed == ((1 << PW) >> m_rate) - 1) && k < 64) begin
            cyc(0, 3'd0, 4'd0);
            k++;
        end
        check_val("hit_reached", k < 64, 1);
    endtask

    initial begin
        int n;
        logic [3:0] held;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = 3'd0;
        ifc.cmd_data  = 4'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_val("init_count", count_out, 0);
        check_val("init_running", running, 0);
        check_val("init_ready", ifc.cmd_ready, 1);
        rst = 1'b1;

        // Async reset while running at count 5.
        cyc(1, 3'd4, 4'd5);
        cyc(1, 3'd1, 4'd0);
        repeat (5) cyc(0, 3'd0, 4'd0);
        check_val("s1_count5", count_out, 5);
        reset_mid();

        // Rate 0: first tick 16 cycles after running rises, then wrap to 0.
        cyc(1, 3'd1, 4'd0);
        check_val("s2_running", running, 1);
        wait_tick(n);
        check_val("s2_first_tick", n, 16);
        n = 0;
        while (!wrap && n < 300) begin
            cyc(0, 3'd0, 4'd0);
            n++;
        end
        check_val("s2_wrap_seen", wrap, 1);
        check_val("s2_wrap_count", count_out, 0);
        cyc(1, 3'd2, 4'd0);

        // Rate 2 gives period 4; rate 9 saturates to 3 giving period 2.
        cyc(1, 3'd5, 4'd2);
        cyc(1, 3'd1, 4'd0);
        wait_tick(n);
        wait_tick(n);
        check_val("s3_period4", n, 4);
        cyc(1, 3'd5, 4'd9);
        wait_tick(n);
        wait_tick(n);
        check_val("s3_period2", n, 2);
        cyc(1, 3'd2, 4'd0);

        // STEP from 15 wraps to 0; STEP while running is an error.
        cyc(1, 3'd4, 4'd15);
        cyc(1, 3'd3, 4'd0);
        check_val("s4_ready_low", ifc.cmd_ready, 0);
        cyc(0, 3'd0, 4'd0);
        check_val("s4_step_count", count_out, 0);
        check_val("s4_step_wrap", wrap, 1);
        cyc(1, 3'd1, 4'd0);
        cyc(1, 3'd3, 4'd0);
        check_val("s4_step_err", cmd_err, 1);

        // LOAD and STOP landing on the terminal cycle.
        wait_hit();
        cyc(1, 3'd4, 4'hA);
        check_val("s5_load_a", count_out, 4'hA);
        check_val("s5_load_notick", tick, 0);
        wait_hit();
        held = count_out;
        cyc(1, 3'd2, 4'd0);
        check_val("s5_stop_held", count_out, held);
        check_val("s5_stop_running", running, 0);
        check_val("s5_stop_notick", tick, 0);

`ifdef COUNT_CTRL_DOWN_EN
        cyc(1, 3'd6, 4'd1);
        cyc(1, 3'd4, 4'd0);
        cyc(1, 3'd3, 4'd0);
        cyc(0, 3'd0, 4'd0);
        check_val("s6_down_count", count_out, 15);
        check_val("s6_down_wrap", wrap, 1);
        cyc(1, 3'd6, 4'd0);
`else
        cyc(1, 3'd4, 4'd3);
        cyc(1, 3'd6, 4'd1);
        check_val("s6_dir_err", cmd_err, 1);
        check_val("s6_dir_count", count_out, 3);
`endif

        // Random traffic, occasional async reset.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                reset_mid();
            end else begin
                cyc($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
